pipe_bitcount: RTL

PIPE_BITCOUNT -- requirements
Module: pipe_bitcount

---
 rtl/pipe_bitcount.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_bitcount.sv
// rtl/pipe_bitcount.sv - pipelined popcount / leading-count unit with tag sideband
module pipe_bitcount #(
    parameter int LG_N  = 5,
    parameter int LAT   = 2,
    parameter int TAG_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [(1<<LG_N)-1:0]  in_data,
    input  logic [1:0]            in_mode,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LG_N:0]         out_result,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  busy
);
    localparam int N = 1 << LG_N;

    // One count slot per leaf; level k of the tree keeps its N>>k node counts
    // in the low slots, so the final count ends up in slot 0.
    typedef logic [N-1:0][LG_N:0] vec_t;

    logic [N-1:0]     leaf_bits;
    vec_t             leaf;
    vec_t             cnt_d  [LAT];
    vec_t             cnt_q  [LAT];
    logic [1:0]       mode_q [LAT];
    logic [TAG_W-1:0] tag_q  [LAT];
    logic [LAT-1:0]   valid_q;
    logic             advance;
    logic             unused_bits;

    // All four modes reduce to "count ones" or "count leading ones" of a
    // possibly inverted operand: POPZ and CLZ invert, POPC and CLO do not.
    // mode[1] selects the leading-count flavour.
    function automatic vec_t reduce_levels(input vec_t a, input logic lead,
                                           input int lo, input int hi);
        vec_t           r;
        logic [LG_N:0]  half;
        logic [LG_N:0]  c_hi;
        logic [LG_N:0]  c_lo;
        r = a;
        for (int k = 1; k <= LG_N; k++) begin
            if (k > lo && k <= hi) begin
                half = (LG_N+1)'(1 << (k - 1));
                for (int i = 0; i < N / 2; i++) begin
                    if (i < (N >> k)) begin
                        c_hi = r[2*i+1];
                        c_lo = r[2*i];
                        // Leading run only extends into the low half when
                        // the high half is entirely ones.
                        r[i] = (lead && c_hi != half) ? c_hi : c_hi + c_lo;
                    end
                end
            end
        end
        return r;
    endfunction

    assign leaf_bits = in_data ^ {N{in_mode[0] ^ in_mode[1]}};

    // Tree leaves: one single-bit count per operand bit.
    always_comb begin
        leaf = '0;
        for (int i = 0; i < N; i++) begin
            leaf[i] = {{LG_N{1'b0}}, leaf_bits[i]};
        end
    end

    // Tree levels are split evenly across the LAT register stages.
    always_comb begin
        for (int s = 0; s < LAT; s++) begin
            if (s == 0) begin
                cnt_d[s] = reduce_levels(leaf, in_mode[1], 0, LG_N / LAT);
            end else begin
                cnt_d[s] = reduce_levels(cnt_q[(s == 0) ? 0 : s - 1],
                                         mode_q[(s == 0) ? 0 : s - 1][1],
                                         s * LG_N / LAT, (s + 1) * LG_N / LAT);
            end
        end
    end

    // Stage registers: global stall, flush clears valids even when stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                cnt_q[s]  <= '0;
                mode_q[s] <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            if (flush) begin
                valid_q <= '0;
            end else if (advance) begin
                valid_q <= (valid_q << 1) | LAT'(in_valid);
            end
            if (advance) begin
                cnt_q[0]  <= cnt_d[0];
                mode_q[0] <= in_mode;
                tag_q[0]  <= in_tag;
                for (int s = 1; s < LAT; s++) begin
                    cnt_q[s]  <= cnt_d[s];
                    mode_q[s] <= mode_q[s-1];
                    tag_q[s]  <= tag_q[s-1];
                end
            end
        end
    end

    assign advance    = !out_valid || out_ready;
    // A flush cycle always reports ready; whatever it takes is discarded.
    assign in_ready   = advance || flush;
    assign out_valid  = valid_q[LAT-1];
    assign out_result = cnt_q[LAT-1][0];
    assign out_tag    = tag_q[LAT-1];
    assign busy       = |valid_q;

    // Upper slots of the last stage and its mode are never consumed.
    assign unused_bits = ^{cnt_q[LAT-1][N-1:1], mode_q[LAT-1]};

endmodule
